gelato_warp_scheduler: RTL and testbench

Fetch-side warp scheduler between the per-warp split tables' PC-table outputs and the instruction fetch stage. Each cycle it picks one eligible warp, round-robin, and places its PC and split-table entry number in a registered valid/ready slot for fetch. The chosen warp is then marked in flight and stays ineligible until decode sends the activate pulse for it. This makes sure each warp has at most one instruction between fetch and decode.

---
 rtl/gelato_warp_scheduler_pkg.sv | 29 ++
 rtl/gelato_warp_scheduler_rr_arbiter.sv | 46 ++++
 rtl/gelato_warp_scheduler.sv | 116 +++++++++++
 tb/tb_gelato_warp_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gelato_warp_scheduler_pkg.sv
// gelato_warp_scheduler_pkg
//   Shared types for the fetch-side warp scheduler.
//   - WARP_NUM / WARP_NUM_WIDTH / PC_WIDTH / SPLIT_NUM_WIDTH: default geometry
//   - warp_num_t, pc_t, split_table_num_t: scalar field types
//   - sched_req_t: contents of the registered fetch request slot
//   - sched_state_e: per-warp fetch state (one bit per warp)
package gelato_warp_scheduler_pkg;

  localparam int WARP_NUM        = 4;
  localparam int WARP_NUM_WIDTH  = $clog2(WARP_NUM);
  localparam int PC_WIDTH        = 32;
  localparam int SPLIT_NUM_WIDTH = 2;

  typedef logic [WARP_NUM_WIDTH-1:0]  warp_num_t;
  typedef logic [PC_WIDTH-1:0]        pc_t;
  typedef logic [SPLIT_NUM_WIDTH-1:0] split_table_num_t;

  typedef enum logic {
    WARP_IDLE     = 1'b0,
    WARP_INFLIGHT = 1'b1
  } sched_state_e;

  typedef struct packed {
    warp_num_t        warp_num;
    pc_t              pc;
    split_table_num_t split_table_num;
  } sched_req_t;

endpackage

// File: rtl/gelato_warp_scheduler_rr_arbiter.sv
// gelato_rr_arbiter
//   Combinational round-robin arbiter. Searches req starting at ptr and
//   wrapping modulo WARP_NUM; the first set request wins.
//   Ports:
//     req       in  WARP_NUM        request vector
//     ptr       in  WARP_NUM_WIDTH  search start index
//     gnt_valid out 1               some request is set
//     gnt_idx   out WARP_NUM_WIDTH  index of the winning request
module gelato_rr_arbiter #(
  parameter int WARP_NUM       = 4,
  parameter int WARP_NUM_WIDTH = $clog2(WARP_NUM)
) (
  input  logic [WARP_NUM-1:0]       req,
  input  logic [WARP_NUM_WIDTH-1:0] ptr,
  output logic                      gnt_valid,
  output logic [WARP_NUM_WIDTH-1:0] gnt_idx
);

  // rot_req[k] is the request k positions after ptr. WARP_NUM is a power
  // of two, so the index wraps by plain truncation of the sum.
  logic [WARP_NUM-1:0]       rot_req;
  logic [WARP_NUM_WIDTH-1:0] gnt_off;

  genvar gi;
  generate
    for (gi = 0; gi < WARP_NUM; gi++) begin : g_rot
      logic [WARP_NUM_WIDTH-1:0] src_idx;
      assign src_idx     = ptr + WARP_NUM_WIDTH'(gi);
      assign rot_req[gi] = req[src_idx];
    end
  endgenerate

  // Scan from the far end so the lowest offset from ptr is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_off   = '0;
    for (int k = WARP_NUM - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        gnt_valid = 1'b1;
        gnt_off   = WARP_NUM_WIDTH'(k);
      end
    end
    gnt_idx = ptr + gnt_off;
  end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// gelato_warp_scheduler
//   Picks one eligible warp per cycle (round-robin) and places its PC and
//   split-table entry in a registered valid/ready slot for fetch. A granted
//   warp stays in flight until decode releases it with an activate pulse,
//   so each warp has at most one instruction between fetch and decode.
//   Ports:
//     clk, rst_n          clock (rising edge), synchronous active-low reset
//     rdy                 global enable; 0 freezes all state
//     warp_valid          per-warp active split-table entry
//     warp_pc             per-warp selected PC
//     warp_split_num      per-warp selected split-table entry
//     activate_valid      decode releases warp activate_warp_num
//     activate_warp_num   warp being released
//     fetch_valid/ready   request slot handshake
//     fetch_warp_num      warp of the request
//     fetch_pc            PC of the request
//     fetch_split_num     split entry of the request
//     inflight            per-warp in-flight flags
//   The slot register uses the package field widths; parameters must keep
//   their default values unless the package is changed to match.
module gelato_warp_scheduler
  import gelato_warp_scheduler_pkg::*;
#(
  parameter int WARP_NUM        = gelato_warp_scheduler_pkg::WARP_NUM,
  parameter int WARP_NUM_WIDTH  = $clog2(WARP_NUM),
  parameter int PC_WIDTH        = gelato_warp_scheduler_pkg::PC_WIDTH,
  parameter int SPLIT_NUM_WIDTH = gelato_warp_scheduler_pkg::SPLIT_NUM_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      rdy,
  input  logic [WARP_NUM-1:0]                       warp_valid,
  input  logic [WARP_NUM-1:0][PC_WIDTH-1:0]         warp_pc,
  input  logic [WARP_NUM-1:0][SPLIT_NUM_WIDTH-1:0]  warp_split_num,
  input  logic                                      activate_valid,
  input  logic [WARP_NUM_WIDTH-1:0]                 activate_warp_num,
  output logic                                      fetch_valid,
  input  logic                                      fetch_ready,
  output logic [WARP_NUM_WIDTH-1:0]                 fetch_warp_num,
  output logic [PC_WIDTH-1:0]                       fetch_pc,
  output logic [SPLIT_NUM_WIDTH-1:0]                fetch_split_num,
  output logic [WARP_NUM-1:0]                       inflight
);

  sched_req_t                slot_reg;
  logic                      fetch_valid_reg;
  logic [WARP_NUM-1:0]       inflight_reg;
  logic [WARP_NUM-1:0]       inflight_next;
  logic [WARP_NUM_WIDTH-1:0] ptr_reg;

  logic [WARP_NUM-1:0]       eligible;
  logic                      fire;
  logic                      slot_free;
  logic                      gnt_valid;
  logic [WARP_NUM_WIDTH-1:0] gnt_idx;
  logic                      grant;
  sched_req_t                grant_req;

  assign eligible  = warp_valid & ~inflight_reg;
  assign fire      = fetch_valid_reg & fetch_ready;
  assign slot_free = ~fetch_valid_reg | fire;
  assign grant     = rdy & slot_free & gnt_valid;

  gelato_rr_arbiter #(
    .WARP_NUM       (WARP_NUM),
    .WARP_NUM_WIDTH (WARP_NUM_WIDTH)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant_req.warp_num        = gnt_idx;
  assign grant_req.pc              = warp_pc[gnt_idx];
  assign grant_req.split_table_num = warp_split_num[gnt_idx];

  // Activate clears, grant sets. A grant only targets an IDLE warp, so the
  // two never fight over the same bit in a meaningful way.
  genvar gi;
  generate
    for (gi = 0; gi < WARP_NUM; gi++) begin : g_inflight
      logic act_hit;
      logic gnt_hit;
      assign act_hit = activate_valid && (activate_warp_num == WARP_NUM_WIDTH'(gi));
      assign gnt_hit = grant && (gnt_idx == WARP_NUM_WIDTH'(gi));
      assign inflight_next[gi] = gnt_hit ? WARP_INFLIGHT
                               : (act_hit ? WARP_IDLE : inflight_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_reg        <= '0;
      fetch_valid_reg <= 1'b0;
      inflight_reg    <= '0;
      ptr_reg         <= '0;
    end else if (rdy) begin
      inflight_reg <= inflight_next;
      if (grant) begin
        slot_reg        <= grant_req;
        fetch_valid_reg <= 1'b1;
        ptr_reg         <= gnt_idx + 1'b1;
      end else if (fire) begin
        fetch_valid_reg <= 1'b0;
      end
    end
  end

  assign fetch_valid     = fetch_valid_reg;
  assign fetch_warp_num  = slot_reg.warp_num;
  assign fetch_pc        = slot_reg.pc;
  assign fetch_split_num = slot_reg.split_table_num;
  assign inflight        = inflight_reg;

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
module tb_gelato_warp_scheduler;

  logic             clk;
  logic             rst_n;
  logic             rdy;
  logic [3:0]       warp_valid;
  logic [3:0][31:0] warp_pc;
  logic [3:0][1:0]  warp_split_num;
  logic             activate_valid;
  logic [1:0]       activate_warp_num;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [1:0]       fetch_warp_num;
  logic [31:0]      fetch_pc;
  logic [1:0]       fetch_split_num;
  logic [3:0]       inflight;

  int checks = 0;
  int errors = 0;

  gelato_warp_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .warp_valid        (warp_valid),
    .warp_pc           (warp_pc),
    .warp_split_num    (warp_split_num),
    .activate_valid    (activate_valid),
    .activate_warp_num (activate_warp_num),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_warp_num    (fetch_warp_num),
    .fetch_pc          (fetch_pc),
    .fetch_split_num   (fetch_split_num),
    .inflight          (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [3:0] warp_valid;
    logic       fetch_ready;
    logic       act_valid;
    logic [1:0] act_num;
    logic       exp_fv;
    logic [1:0] exp_warp;
    logic [3:0] exp_infl;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic fv, input logic [1:0] w,
                             input logic [31:0] pc, input logic [3:0] infl);
    $display("%s: fv=%0b warp=%0d pc=0x%0h split=%0d inflight=%b",
             name, fetch_valid, fetch_warp_num, fetch_pc, fetch_split_num, inflight);
    check({name, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
    check({name, ".inflight"}, 32'(inflight), 32'(infl));
    if (fv) begin
      check({name, ".warp"}, 32'(fetch_warp_num), 32'(w));
      check({name, ".pc"}, fetch_pc, pc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic default_pcs();
    for (int i = 0; i < 4; i++) begin
      warp_pc[i]        = 32'h1000 + 32'(i * 4);
      warp_split_num[i] = 2'(i);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; warp_valid = '0; fetch_ready = 1'b0;
    activate_valid = 1'b0; activate_warp_num = '0;
    default_pcs();

    // Main round-robin flow: all warps valid, fetch always ready.
    //          rdy   valid   frdy  act   anum  fv    warp  inflight
    vecs[0]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0001};
    vecs[1]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0011};
    vecs[2]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0111};
    vecs[3]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'b1111};
    vecs[4]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111};
    vecs[5]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 4'b1011};
    vecs[6]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b1111};
    vecs[7]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'b1110};
    vecs[8]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b1111};
    vecs[9]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1101};
    vecs[10] = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 4'b0111};

    tick();
    do_reset();
    check_state("reset", 1'b0, 2'd0, 32'h0, 4'b0000);
    check("reset.pc_zero", fetch_pc, 32'h0);
    check("reset.warp_zero", 32'(fetch_warp_num), 32'h0);
    check("reset.split_zero", 32'(fetch_split_num), 32'h0);

    for (int v = 0; v < 11; v++) begin
      rdy               = vecs[v].rdy;
      warp_valid        = vecs[v].warp_valid;
      fetch_ready       = vecs[v].fetch_ready;
      activate_valid    = vecs[v].act_valid;
      activate_warp_num = vecs[v].act_num;
      tick();
      check_state($sformatf("vec%0d", v), vecs[v].exp_fv, vecs[v].exp_warp,
                  32'h1000 + 32'(vecs[v].exp_warp) * 4, vecs[v].exp_infl);
      if (vecs[v].exp_fv)
        check($sformatf("vec%0d.split", v), 32'(fetch_split_num), 32'(vecs[v].exp_warp));
    end
    activate_valid = 1'b0;

    // Stall: payload captured at grant stays put while fetch_ready=0.
    do_reset();
    warp_pc[1] = 32'h100; warp_valid = 4'b0010; fetch_ready = 1'b0;
    tick();
    check_state("stall.grant", 1'b1, 2'd1, 32'h100, 4'b0010);
    warp_valid = 4'b1111; warp_pc[1] = 32'h200;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_state($sformatf("stall.hold%0d", c), 1'b1, 2'd1, 32'h100, 4'b0010);
    end
    fetch_ready = 1'b1;
    tick();
    check_state("stall.accept", 1'b1, 2'd2, 32'h1008, 4'b0110);

    // rdy=0: nothing moves, activate is dropped.
    rdy = 1'b0; activate_valid = 1'b1; activate_warp_num = 2'd1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_state($sformatf("frozen%0d", c), 1'b1, 2'd2, 32'h1008, 4'b0110);
    end
    rdy = 1'b1; activate_valid = 1'b0; fetch_ready = 1'b0;
    tick();
    check_state("frozen.after", 1'b1, 2'd2, 32'h1008, 4'b0110);

    // Reset mid-operation drops the request and the in-flight flags.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_state("midreset", 1'b0, 2'd0, 32'h0, 4'b0000);
    check("midreset.pc_zero", fetch_pc, 32'h0);
    tick();
    check_state("midreset.regrant", 1'b1, 2'd0, 32'h1000, 4'b0001);

    // Wrap-around: ptr=1 with warps 0 and 3 valid.
    do_reset();
    default_pcs();
    warp_valid = 4'b0001; fetch_ready = 1'b1;
    tick();
    check_state("wrap.setup", 1'b1, 2'd0, 32'h1000, 4'b0001);
    warp_valid = 4'b1001; activate_valid = 1'b1; activate_warp_num = 2'd0;
    tick();
    check_state("wrap.first", 1'b1, 2'd3, 32'h100C, 4'b1000);
    activate_valid = 1'b0;
    tick();
    check_state("wrap.second", 1'b1, 2'd0, 32'h1000, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
